// File: rtl/btn_pkg.sv
// Shared definitions for the five-button conditioner.
// Holds the per-channel FSM state encoding and the bit index of each
// physical button within the 5-bit button buses.
// No ports: this is a package, imported by btn_channel and btn_conditioner.
package btn_pkg;

  // Number of buttons on the board: {btnD, btnR, btnL, btnU, btnC}.
  localparam int NUM_BTNS = 5;

  // Bit positions of each button inside btn_raw / btn_level / pulse buses.
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, debounce counter
// and auto-repeat counter.
// Ports:
//   clock_100mhz  in   sole clock, rising edge
//   reset         in   asynchronous active-high reset
//   btn_raw       in   unsynchronised button input
//   btn_level     out  debounced level (registered)
//   btn_press     out  one-cycle pulse on accepted press (registered)
//   btn_release   out  one-cycle pulse on accepted release (registered)
//   btn_repeat    out  one-cycle auto-repeat pulse while held (registered)
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clock_100mhz,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int RCW = $clog2(REPEAT_DELAY) + 1;

  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RCNT_FIRE = RCW'(REPEAT_DELAY);
  // After a repeat pulse rcnt is pulled back so that it reaches RCNT_FIRE
  // again after REPEAT_PERIOD further HELD cycles; this keeps rcnt bounded
  // and avoids any wrap-around pulse. A period longer than the initial
  // delay is clamped to the delay, since rcnt cannot hold a larger span.
  localparam logic [RCW-1:0] RCNT_RELOAD = (REPEAT_PERIOD < REPEAT_DELAY) ?
                                           RCW'(REPEAT_DELAY - REPEAT_PERIOD) : '0;

  logic [1:0]     sync_q, sync_d;
  btn_state_e     state_q, state_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [RCW-1:0] rcnt_inc;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           rel_q, rel_d;
  logic           rep_q, rep_d;
  logic           s;

  assign s = sync_q[1];

  // Next-state logic. Pulses default low so each lasts exactly one cycle.
  // rcnt advances on every cycle spent in HELD (including the one in which
  // the input first drops) and is left untouched in DEB_REL, so a short
  // release glitch only delays the repeat cadence by the glitch length.
  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    rcnt_d   = rcnt_q;
    level_d  = level_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    rep_d    = 1'b0;
    rcnt_inc = rcnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_DEB_PRESS;
          dcnt_d  = '0;
        end
      end

      ST_DEB_PRESS: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      ST_HELD: begin
        if (rcnt_inc == RCNT_FIRE) begin
          rep_d  = 1'b1;
          rcnt_d = RCNT_RELOAD;
        end else begin
          rcnt_d = rcnt_inc;
        end
        if (!s) begin
          state_d = ST_DEB_REL;
          dcnt_d  = '0;
        end
      end

      ST_DEB_REL: begin
        if (s) begin
          state_d = ST_HELD;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // All state, counters and outputs live in one register bank so every
  // output is a flop and reset clears everything, including the synchroniser.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rep_q   <= rep_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign btn_repeat  = rep_q;

endmodule

// File: rtl/btn_conditioner.sv
// Five-button conditioner: one independent btn_channel per button.
// Ports:
//   clock_100mhz  in   sole clock, rising edge
//   reset         in   asynchronous active-high reset
//   btn_raw       in   [4:0] raw buttons {btnD, btnR, btnL, btnU, btnC}
//   btn_level     out  [4:0] debounced levels
//   btn_press     out  [4:0] one-cycle press pulses
//   btn_release   out  [4:0] one-cycle release pulses
//   btn_repeat    out  [4:0] one-cycle auto-repeat pulses
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clock_100mhz,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_repeat
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clock_100mhz(clock_100mhz),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=5. Stimulus pushes the hand-computed pulse events it expects
// (absolute cycle plus press/release/repeat/level vectors) into a queue; an
// independent monitor pops and compares whenever the DUT shows any pulse.
module tb_btn_conditioner;

  logic       clock_100mhz;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic [4:0] btn_repeat;

  int cyc   = 0;
  int nvec  = 0;
  int nmiss = 0;

  typedef struct {
    int         cyc;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] rep;
    logic [4:0] lvl;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;
  ev_t drop_ev;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clock_100mhz(clock_100mhz),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  // 100 MHz clock.
  initial clock_100mhz = 1'b0;
  always #5 clock_100mhz = ~clock_100mhz;

  // Free-running cycle number, used to timestamp expected pulses.
  always @(posedge clock_100mhz) cyc <= cyc + 1;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [4:0] got,
                             input logic [4:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, exp);
    end
  endtask

  // Drive the raw buttons now (caller sits on a falling edge) and hold them
  // for the given number of cycles.
  task automatic applyStimulus(input logic [4:0] raw, input int hold);
    btn_raw = raw;
    repeat (hold) @(negedge clock_100mhz);
  endtask

  // Record one expected pulse event for the monitor.
  task automatic expectEvent(input int c, input logic [4:0] p, input logic [4:0] r,
                             input logic [4:0] rp, input logic [4:0] lv);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rep = rp; e.lvl = lv;
    sb.push_back(e);
  endtask

  // Monitor: on every falling edge flag expected events whose cycle has
  // passed unseen, then match any visible pulse against the queue head.
  always @(negedge clock_100mhz) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      nvec++;
      nmiss++;
      $display("[TB] FAIL missed_event: expected pulse at cycle %0d, not observed by cycle %0d",
               sb[0].cyc, cyc);
      drop_ev = sb.pop_front();
    end
    if ((btn_press | btn_release | btn_repeat) != 5'b0) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_ev = sb.pop_front();
        checkOutput("press",   btn_press,   mon_ev.press);
        checkOutput("release", btn_release, mon_ev.rel);
        checkOutput("repeat",  btn_repeat,  mon_ev.rep);
        checkOutput("level",   btn_level,   mon_ev.lvl);
      end else begin
        nvec++;
        nmiss++;
        $display("[TB] FAIL unexpected_pulse at cycle %0d: press=%b release=%b repeat=%b, expected none",
                 cyc, btn_press, btn_release, btn_repeat);
      end
    end
  end

  // Directed scenarios. Press/release appear 7 cycles after the raw edge
  // (2 sync + 1 FSM entry + 4 debounce); repeats at 20 then every 5 HELD cycles.
  initial begin : stim
    int t;
    reset   = 1'b1;
    btn_raw = 5'b0;
    repeat (3) @(negedge clock_100mhz);
    checkOutput("reset_level",   btn_level,   5'b0);
    checkOutput("reset_press",   btn_press,   5'b0);
    checkOutput("reset_release", btn_release, 5'b0);
    checkOutput("reset_repeat",  btn_repeat,  5'b0);
    reset = 1'b0;
    repeat (5) @(negedge clock_100mhz);

    // Clean press on btnC, held 40 cycles.
    $display("[TB] clean press btnC");
    t = cyc;
    expectEvent(t + 7,  5'b00001, 5'b0, 5'b0, 5'b00001);
    expectEvent(t + 27, 5'b0, 5'b0, 5'b00001, 5'b00001);
    expectEvent(t + 32, 5'b0, 5'b0, 5'b00001, 5'b00001);
    expectEvent(t + 37, 5'b0, 5'b0, 5'b00001, 5'b00001);
    expectEvent(t + 42, 5'b0, 5'b0, 5'b00001, 5'b00001);
    expectEvent(t + 47, 5'b0, 5'b00001, 5'b0, 5'b00000);
    applyStimulus(5'b00001, 20);
    checkOutput("held_level_btnC", btn_level, 5'b00001);
    applyStimulus(5'b00001, 20);
    applyStimulus(5'b00000, 20);

    // Bounce on btnL: 2-cycle pulses never survive the debounce.
    $display("[TB] bounce btnL");
    applyStimulus(5'b00100, 2);
    applyStimulus(5'b00000, 2);
    applyStimulus(5'b00100, 2);
    applyStimulus(5'b00000, 20);
    checkOutput("bounce_level", btn_level, 5'b00000);

    // btnU held, 2-cycle drop at cycle 30: repeats after the drop slip by 2.
    $display("[TB] release glitch btnU");
    t = cyc;
    expectEvent(t + 7,  5'b00010, 5'b0, 5'b0, 5'b00010);
    expectEvent(t + 27, 5'b0, 5'b0, 5'b00010, 5'b00010);
    expectEvent(t + 32, 5'b0, 5'b0, 5'b00010, 5'b00010);
    expectEvent(t + 39, 5'b0, 5'b0, 5'b00010, 5'b00010);
    expectEvent(t + 44, 5'b0, 5'b0, 5'b00010, 5'b00010);
    expectEvent(t + 49, 5'b0, 5'b0, 5'b00010, 5'b00010);
    expectEvent(t + 54, 5'b0, 5'b0, 5'b00010, 5'b00010);
    expectEvent(t + 59, 5'b0, 5'b00010, 5'b0, 5'b00000);
    applyStimulus(5'b00010, 30);
    applyStimulus(5'b00000, 2);
    applyStimulus(5'b00010, 4);
    checkOutput("glitch_level_btnU", btn_level, 5'b00010);
    applyStimulus(5'b00010, 16);
    applyStimulus(5'b00000, 15);

    // Simultaneous press and release on btnD, btnL, btnC.
    $display("[TB] simultaneous 10101");
    t = cyc;
    expectEvent(t + 7,  5'b10101, 5'b0, 5'b0, 5'b10101);
    expectEvent(t + 17, 5'b0, 5'b10101, 5'b0, 5'b00000);
    applyStimulus(5'b10101, 10);
    applyStimulus(5'b00000, 15);

    // Reset while btnD is held: no release, fresh press after reset.
    $display("[TB] reset mid-hold btnD");
    t = cyc;
    expectEvent(t + 7, 5'b10000, 5'b0, 5'b0, 5'b10000);
    applyStimulus(5'b10000, 10);
    checkOutput("prereset_level", btn_level, 5'b10000);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock_100mhz);
      checkOutput("inreset_level",   btn_level,   5'b0);
      checkOutput("inreset_press",   btn_press,   5'b0);
      checkOutput("inreset_release", btn_release, 5'b0);
      checkOutput("inreset_repeat",  btn_repeat,  5'b0);
    end
    reset = 1'b0;
    t = cyc;
    expectEvent(t + 7,  5'b10000, 5'b0, 5'b0, 5'b10000);
    expectEvent(t + 22, 5'b0, 5'b10000, 5'b0, 5'b00000);
    applyStimulus(5'b10000, 15);
    applyStimulus(5'b00000, 20);

    // Every expected event must have been consumed by now.
    nvec++;
    if (sb.size() != 0) begin
      nmiss++;
      $display("[TB] FAIL scoreboard_drain: %0d events left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
